// File: rtl/ps2_pkg.sv
// Shared PS/2 port definitions: transmitter states, filter depth default and frame parity.
package ps2_pkg;

    localparam int unsigned DEFAULT_FILTER_LEN = 8;
    localparam int unsigned FRAME_BITS         = 9;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        ACK,
        WAIT_IDLE
    } state_t;

    // Odd parity: the parity bit makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock pin with one-cycle fall/rise pulses.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic clk_f,
    output logic fall,
    output logic rise
);

    logic [FILTER_LEN-1:0] shreg;
    logic                  clk_f_next;

    // Filtered level only moves once every sample agrees.
    always_comb begin
        clk_f_next = clk_f;
        if (&shreg) begin
            clk_f_next = 1'b1;
        end else if (~|shreg) begin
            clk_f_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '1;
            clk_f <= 1'b1;
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            shreg <= {ps2c, shreg[FILTER_LEN-1:1]};
            clk_f <= clk_f_next;
            fall  <= clk_f & ~clk_f_next;
            rise  <= ~clk_f & clk_f_next;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock, ack check.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = DEFAULT_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_ack_err
);

    localparam int unsigned      CNT_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_DATA = CNT_W'(INHIBIT_CYCLES - 2);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [FRAME_BITS-1:0]   sh, sh_next;
    logic [3:0]              n, n_next;
    logic                    ack_err, ack_err_next;
    logic                    ps2c_oe_next, ps2d_oe_next, tx_idle_next;
    logic                    tx_done_tick_next, tx_ack_err_next;
    logic                    clk_f, fall, rise_unused;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk   (clk),
        .reset (reset),
        .ps2c  (ps2c),
        .clk_f (clk_f),
        .fall  (fall),
        .rise  (rise_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sh           <= '0;
            n            <= '0;
            ack_err      <= 1'b0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b0;
            tx_ack_err   <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            sh           <= sh_next;
            n            <= n_next;
            ack_err      <= ack_err_next;
            ps2c_oe      <= ps2c_oe_next;
            ps2d_oe      <= ps2d_oe_next;
            tx_idle      <= tx_idle_next;
            tx_done_tick <= tx_done_tick_next;
            tx_ack_err   <= tx_ack_err_next;
        end
    end

    // Next state and next values of the registered pin enables/status.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        sh_next           = sh;
        n_next            = n;
        ack_err_next      = ack_err;
        ps2c_oe_next      = 1'b0;
        ps2d_oe_next      = 1'b0;
        tx_done_tick_next = 1'b0;
        tx_ack_err_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (wr_ps2) begin
                    state_next   = RTS;
                    cnt_next     = '0;
                    sh_next      = {odd_parity(din), din};
                    n_next       = 4'd8;
                    ps2c_oe_next = 1'b1;
                end
            end
            RTS: begin
                cnt_next     = cnt + CNT_W'(1);
                ps2c_oe_next = 1'b1;
                ps2d_oe_next = (cnt >= RTS_DATA);
                if (cnt == RTS_LAST) begin
                    state_next   = START;
                    ps2c_oe_next = 1'b0;
                    ps2d_oe_next = 1'b1;
                end
            end
            START: begin
                ps2d_oe_next = 1'b1;
                if (fall) begin
                    state_next   = DATA;
                    ps2d_oe_next = ~sh[0];
                end
            end
            DATA: begin
                ps2d_oe_next = ~sh[0];
                if (fall) begin
                    if (n == 4'd0) begin
                        state_next   = STOP;
                        ps2d_oe_next = 1'b0;
                    end else begin
                        sh_next      = {1'b0, sh[FRAME_BITS-1:1]};
                        n_next       = n - 4'd1;
                        ps2d_oe_next = ~sh[1];
                    end
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    ack_err_next = ps2d;
                    state_next   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // Bus must be fully released before the host may start again.
                if (clk_f && ps2d) begin
                    state_next        = IDLE;
                    tx_done_tick_next = 1'b1;
                    tx_ack_err_next   = ack_err;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_idle_next = (state_next == IDLE);
    end

endmodule
